// File: rtl/style_query_issuer.sv
// Style-query issuer: buffers element style queries, issues them one at a time to the display/class
// comparators and returns the registered verdicts over valid/ready. Optional counters: STYLE_QUERY_STATS_EN.
module style_query_issuer #(
  parameter int         DEPTH           = 4,
  parameter logic [5:0] NOPSEUDO_CODE   = 6'd0,
  parameter logic [4:0] NONE_CODE       = 5'd0,
  parameter logic [4:0] INLINE_CODE     = 5'd1,
  parameter logic [4:0] BLOCK_CODE      = 5'd2,
  parameter logic [5:0] PRIM_CLASS_CODE = 6'd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_elem_id,
  input  logic                     in_is_svg,
  input  logic [5:0]               in_style_type,
  input  logic [4:0]               in_display,
  input  logic [5:0]               in_class_type,
  output logic                     chk_element_valid,
  output logic                     chk_is_svg_element,
  output logic [5:0]               chk_style_type,
  output logic [4:0]               chk_display,
  output logic [5:0]               chk_class_type,
  output logic [5:0]               chk_nopseudo,
  output logic [4:0]               chk_none,
  output logic [4:0]               chk_inline,
  output logic [4:0]               chk_block,
  output logic [5:0]               chk_primitive_class,
  input  logic                     chk_is_valid_display_value,
  input  logic                     chk_is_primitive_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_elem_id,
  output logic                     out_display_ok,
  output logic                     out_primitive,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              stat_issued,
  output logic [15:0]              stat_rejected
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t        r_state;
  logic [15:0]   r_mem_id    [DEPTH];
  logic          r_mem_svg   [DEPTH];
  logic [5:0]    r_mem_style [DEPTH];
  logic [4:0]    r_mem_disp  [DEPTH];
  logic [5:0]    r_mem_class [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_chk_id;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign chk_nopseudo        = NOPSEUDO_CODE;
  assign chk_none            = NONE_CODE;
  assign chk_inline          = INLINE_CODE;
  assign chk_block           = BLOCK_CODE;
  assign chk_primitive_class = PRIM_CLASS_CODE;

  // A full FIFO refuses pushes even when a pop happens on the same edge.
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign in_ready   = !w_full;
  assign w_push     = in_valid && !w_full;
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || (r_state == S_HOLD && out_ready));
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]    <= in_elem_id;
      r_mem_svg[r_wr_ptr]   <= in_is_svg;
      r_mem_style[r_wr_ptr] <= in_style_type;
      r_mem_disp[r_wr_ptr]  <= in_display;
      r_mem_class[r_wr_ptr] <= in_class_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_chk_id           <= '0;
      chk_element_valid  <= 1'b0;
      chk_is_svg_element <= 1'b0;
      chk_style_type     <= '0;
      chk_display        <= '0;
      chk_class_type     <= '0;
      out_valid          <= 1'b0;
      out_elem_id        <= '0;
      out_display_ok     <= 1'b0;
      out_primitive      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_ISSUE: begin
          out_elem_id       <= r_chk_id;
          out_display_ok    <= chk_is_valid_display_value;
          out_primitive     <= chk_is_primitive_value;
          out_valid         <= 1'b1;
          chk_element_valid <= 1'b0;
          r_state           <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A pop (from IDLE, or HOLD on release) overrides the transition above and starts the next issue.
      if (w_pop) begin
        r_chk_id           <= r_mem_id[r_rd_ptr];
        chk_is_svg_element <= r_mem_svg[r_rd_ptr];
        chk_style_type     <= r_mem_style[r_rd_ptr];
        chk_display        <= r_mem_disp[r_rd_ptr];
        chk_class_type     <= r_mem_class[r_rd_ptr];
        chk_element_valid  <= 1'b1;
        r_state            <= S_ISSUE;
      end
    end
  end

`ifdef STYLE_QUERY_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_rejected;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_issued   <= '0;
      r_stat_rejected <= '0;
    end else if (r_state == S_ISSUE) begin
      r_stat_issued <= sat_inc(r_stat_issued);
      if (!chk_is_valid_display_value) r_stat_rejected <= sat_inc(r_stat_rejected);
    end
  end

  assign stat_issued   = r_stat_issued;
  assign stat_rejected = r_stat_rejected;
`else
  assign stat_issued   = '0;
  assign stat_rejected = '0;
`endif

endmodule

// File: tb/tb_style_query_issuer.sv
// Directed bench for style_query_issuer with a behavioural comparator and an in-order result scoreboard.
module tb_style_query_issuer;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_elem_id;
  logic        in_is_svg;
  logic [5:0]  in_style_type;
  logic [4:0]  in_display;
  logic [5:0]  in_class_type;
  logic        chk_element_valid;
  logic        chk_is_svg_element;
  logic [5:0]  chk_style_type;
  logic [4:0]  chk_display;
  logic [5:0]  chk_class_type;
  logic [5:0]  chk_nopseudo;
  logic [4:0]  chk_none;
  logic [4:0]  chk_inline;
  logic [4:0]  chk_block;
  logic [5:0]  chk_primitive_class;
  logic        chk_is_valid_display_value;
  logic        chk_is_primitive_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_elem_id;
  logic        out_display_ok;
  logic        out_primitive;
  logic [2:0]  fifo_count;
  logic [15:0] stat_issued;
  logic [15:0] stat_rejected;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] sb[$];

  style_query_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_elem_id(in_elem_id), .in_is_svg(in_is_svg),
    .in_style_type(in_style_type), .in_display(in_display), .in_class_type(in_class_type),
    .chk_element_valid(chk_element_valid), .chk_is_svg_element(chk_is_svg_element),
    .chk_style_type(chk_style_type), .chk_display(chk_display), .chk_class_type(chk_class_type),
    .chk_nopseudo(chk_nopseudo), .chk_none(chk_none), .chk_inline(chk_inline), .chk_block(chk_block),
    .chk_primitive_class(chk_primitive_class),
    .chk_is_valid_display_value(chk_is_valid_display_value),
    .chk_is_primitive_value(chk_is_primitive_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_elem_id(out_elem_id),
    .out_display_ok(out_display_ok), .out_primitive(out_primitive),
    .fifo_count(fifo_count), .stat_issued(stat_issued), .stat_rejected(stat_rejected)
  );

  // Comparators driven from the issuer's query and code outputs
  assign chk_is_valid_display_value = chk_element_valid && chk_is_svg_element &&
    (chk_style_type == chk_nopseudo) &&
    ((chk_display == chk_none) || (chk_display == chk_inline) || (chk_display == chk_block));
  assign chk_is_primitive_value = chk_element_valid && (chk_class_type == chk_primitive_class);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [17:0] model(input logic [15:0] id, input logic svg, input logic [5:0] st,
                                        input logic [4:0] disp, input logic [5:0] cls);
    logic ok;
    logic prim;
    ok   = svg && (st == 6'd0) && (disp == 5'd0 || disp == 5'd1 || disp == 5'd2);
    prim = (cls == 6'd1);
    return {id, ok, prim};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record pushes/handshakes about to happen at the next edge, then advance to 1 time unit past it.
  task automatic tick();
    logic [17:0] e;
    if (rst_n && in_valid && in_ready)
      sb.push_back(model(in_elem_id, in_is_svg, in_style_type, in_display, in_class_type));
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(out_elem_id), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("res_id", 32'(out_elem_id), 32'(e[17:2]));
        check("res_display_ok", 32'(out_display_ok), 32'(e[1]));
        check("res_primitive", 32'(out_primitive), 32'(e[0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] id, input logic svg, input logic [5:0] st,
                      input logic [4:0] disp, input logic [5:0] cls);
    in_valid = 1'b1; in_elem_id = id; in_is_svg = svg;
    in_style_type = st; in_display = disp; in_class_type = cls;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [15:0] snap_id;
  logic        snap_ok;
  logic        snap_prim;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_elem_id = '0; in_is_svg = 1'b0;
    in_style_type = '0; in_display = '0; in_class_type = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_chk_valid", 32'(chk_element_valid), 32'd0);
    check("rst_out_id", 32'(out_elem_id), 32'd0);
    check("const_inline", 32'(chk_inline), 32'd1);
    check("const_block", 32'(chk_block), 32'd2);
    check("const_prim", 32'(chk_primitive_class), 32'd1);
    check("rst_stat_issued", 32'(stat_issued), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single query latency
    out_ready = 1'b1;
    push(16'd7, 1'b1, 6'd0, 5'd1, 6'd0);
    check("t1_valid_n1", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid_n2pre", 32'(out_valid), 32'd0);
    check("t1_chk_valid", 32'(chk_element_valid), 32'd1);
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_id", 32'(out_elem_id), 32'd7);
    check("t1_ok", 32'(out_display_ok), 32'd1);
    drain();

    // Fill with DEPTH+1 queries under backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(16'h20 + 16'(i), 1'b1, 6'd0, 5'(i % 3), 6'(i % 2));
    check("t2_count_full", 32'(fifo_count), 32'd4);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_head_id", 32'(out_elem_id), 32'h20);

    // Backpressure hold, then issue on release edge
    snap_id = out_elem_id; snap_ok = out_display_ok; snap_prim = out_primitive;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_id", 32'(out_elem_id), 32'(snap_id));
      check("t3_hold_ok", 32'(out_display_ok), 32'(snap_ok));
      check("t3_hold_prim", 32'(out_primitive), 32'(snap_prim));
    end
    out_ready = 1'b1;
    tick();
    check("t3_reissue", 32'(chk_element_valid), 32'd1);
    check("t3_count", 32'(fifo_count), 32'd3);
    drain();

    // Mixed verdicts
    push(16'h40, 1'b0, 6'd0, 5'd1, 6'd0);
    push(16'h41, 1'b1, 6'd3, 5'd1, 6'd0);
    push(16'h42, 1'b1, 6'd0, 5'd9, 6'd0);
    push(16'h43, 1'b0, 6'd0, 5'd2, 6'd1);
    drain();

    // Reset while holding a result with two queued
    out_ready = 1'b0;
    push(16'h50, 1'b1, 6'd0, 5'd0, 6'd0);
    push(16'h51, 1'b1, 6'd0, 5'd0, 6'd0);
    push(16'h52, 1'b1, 6'd0, 5'd0, 6'd0);
    tick();
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    check("t5_pre_count", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    check("t5_rst_chk", 32'(chk_element_valid), 32'd0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_no_stale", 32'(out_valid), 32'd0);
    end

    // Statistics: 3 accepted, 2 rejected
    push(16'h60, 1'b1, 6'd0, 5'd0, 6'd0);
    push(16'h61, 1'b0, 6'd0, 5'd1, 6'd0);
    push(16'h62, 1'b1, 6'd0, 5'd1, 6'd1);
    push(16'h63, 1'b1, 6'd2, 5'd2, 6'd0);
    push(16'h64, 1'b1, 6'd0, 5'd2, 6'd0);
    drain();
`ifdef STYLE_QUERY_STATS_EN
    check("t6_issued", 32'(stat_issued), 32'd5);
    check("t6_rejected", 32'(stat_rejected), 32'd2);
`else
    check("t6_issued", 32'(stat_issued), 32'd0);
    check("t6_rejected", 32'(stat_rejected), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
